fetch_flow_ctrl: RTL and testbench

Drives the fetch-control side of the IF stage: instruction_fetch_en, branch_taken and branch_offset_imm. It watches the instruction held in ID, the branch condition and the EX-stage load destination. From these it resolves conditional branches, inserts load-use stalls, holds fetch on external memory stalls, and flushes wrong-path instructions. It sits beside the ID stage, between the hazard sources and the PC logic.

---
 rtl/fetch_flow_if.sv | 30 +++
 rtl/fetch_flow_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_flow_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_flow_if.sv
// fetch_flow_if: groups ID-side hazard inputs and IF-side fetch controls for fetch_flow_ctrl.
// master drives instruction/hazard information; slave (the controller) drives fetch controls.
// Perf counters travel on the same bundle so the PC logic sees one connection.
interface fetch_flow_if;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        rs1_is_zero;
  logic        ex_is_load;
  logic [2:0]  ex_rd;
  logic        mem_stall;
  logic        instruction_fetch_en;
  logic        branch_taken;
  logic [5:0]  branch_offset_imm;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [15:0] stall_count;
  logic [15:0] branch_count;

  modport master (
    output id_instr, id_valid, rs1_is_zero, ex_is_load, ex_rd, mem_stall,
    input  instruction_fetch_en, branch_taken, branch_offset_imm, if_id_flush,
           id_ex_bubble, stall_count, branch_count
  );

  modport slave (
    input  id_instr, id_valid, rs1_is_zero, ex_is_load, ex_rd, mem_stall,
    output instruction_fetch_en, branch_taken, branch_offset_imm, if_id_flush,
           id_ex_bubble, stall_count, branch_count
  );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// fetch_flow_ctrl: resolves branches, load-use stalls, memory stalls and wrong-path flushes for IF.
// Latency: all controls combinational from state and inputs; FSM (RUN/FLUSH/STALL) updates each clk.
// Backpressure: mem_stall freezes fetch in every state; optional perf counters via FETCH_PERF_CNT_EN.
module fetch_flow_ctrl #(
  parameter logic [3:0]  OP_BZ          = 4'b1011,
  parameter logic [3:0]  OP_BNZ         = 4'b1100,
  parameter int unsigned BRANCH_PENALTY = 1
) (
  input logic          clk,
  input logic          rst,
  fetch_flow_if.slave  ffc
);

  typedef enum logic [1:0] {RUN, FLUSH, STALL} state_e;

  // Extra flush cycles after the branch cycle itself.
  localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_PENALTY - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  logic [3:0] opcode;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [5:0] imm6;
  logic       lu;
  logic       bt;

  logic       fetch_en;
  logic       br_taken;
  logic       flush;
  logic       bubble;

  assign opcode = ffc.id_instr[15:12];
  assign rs1    = ffc.id_instr[8:6];
  assign rs2    = ffc.id_instr[5:3];
  assign imm6   = ffc.id_instr[5:0];

  // Field match ignores the instruction format: rs2 may really be imm bits, which
  // only costs an occasional unnecessary stall cycle.
  assign lu = ffc.id_valid & ffc.ex_is_load & (ffc.ex_rd != 3'd0) &
              ((ffc.ex_rd == rs1) | (ffc.ex_rd == rs2));

  assign bt = ffc.id_valid & (((opcode == OP_BZ)  &  ffc.rs1_is_zero) |
                              ((opcode == OP_BNZ) & ~ffc.rs1_is_zero));

  // State and flush counter; async reset aborts any FLUSH/STALL in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and fetch controls; priority mem_stall > load-use > branch, all outputs low in reset.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    fetch_en    = 1'b0;
    br_taken    = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (ffc.mem_stall) begin
            state_d = RUN;
          end else if (lu) begin
            bubble  = 1'b1;
            state_d = STALL;
          end else if (bt) begin
            fetch_en = 1'b1;
            br_taken = 1'b1;
            flush    = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              flush_cnt_d = FLUSH_LOAD;
              state_d     = FLUSH;
            end
          end else begin
            fetch_en = 1'b1;
          end
        end
        STALL: begin
          // The branch is left alone here; RUN re-evaluates it with forwarded operands.
          if (!ffc.mem_stall) begin
            fetch_en = 1'b1;
            state_d  = RUN;
          end
        end
        FLUSH: begin
          flush = 1'b1;
          if (!ffc.mem_stall) begin
            fetch_en    = 1'b1;
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  assign ffc.instruction_fetch_en = fetch_en;
  assign ffc.branch_taken         = br_taken;
  assign ffc.branch_offset_imm    = br_taken ? imm6 : 6'd0;
  assign ffc.if_id_flush          = flush;
  assign ffc.id_ex_bubble         = bubble;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] branch_cnt_q;

  // Saturating perf counters: fetch-disabled cycles and taken-branch pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 16'h0000;
      branch_cnt_q <= 16'h0000;
    end else begin
      if (!fetch_en && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (br_taken && (branch_cnt_q != 16'hFFFF)) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
      end
    end
  end

  assign ffc.stall_count  = stall_cnt_q;
  assign ffc.branch_count = branch_cnt_q;
`else
  assign ffc.stall_count  = 16'h0000;
  assign ffc.branch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// tb_fetch_flow_ctrl: directed checks of fetch_flow_ctrl with BRANCH_PENALTY=1 and =3 side by side.
// Both instances see identical inputs; expected outputs are hand-derived per step.
// Perf counters are checked against a small step model (zero when FETCH_PERF_CNT_EN is undefined).
module tb_fetch_flow_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        rs1_is_zero;
  logic        ex_is_load;
  logic [2:0]  ex_rd;
  logic        mem_stall;

  int n_assert;
  int n_fail;
  int unsigned ms [2];
  int unsigned mb [2];

`ifdef FETCH_PERF_CNT_EN
  localparam logic [15:0] EN_MASK = 16'hFFFF;
`else
  localparam logic [15:0] EN_MASK = 16'h0000;
`endif

  // Instructions: BZ rs1=2 imm=3C; BNZ rs1=3 imm=05; ALU rs1=1 rs2=3; ALU rs1=0 rs2=0; ALU rs1=2 rs2=5
  localparam logic [15:0] BZ_I  = 16'hB0BC;
  localparam logic [15:0] BNZ_I = 16'hC2C5;
  localparam logic [15:0] LU_I  = 16'h0258;
  localparam logic [15:0] Z_I   = 16'h0200;
  localparam logic [15:0] RS1_I = 16'h02A8;

  // Output vector {fetch_en, branch_taken, if_id_flush, id_ex_bubble, offset[5:0]}
  localparam logic [9:0] O0   = 10'b0000_000000;
  localparam logic [9:0] FE   = 10'b1000_000000;
  localparam logic [9:0] FL   = 10'b1010_000000;
  localparam logic [9:0] FLH  = 10'b0010_000000;
  localparam logic [9:0] BUB  = 10'b0001_000000;
  localparam logic [9:0] TK3C = 10'b1110_111100;
  localparam logic [9:0] TK05 = 10'b1110_000101;

  fetch_flow_if if_p1 ();
  fetch_flow_if if_p3 ();

  assign if_p1.id_instr    = id_instr;
  assign if_p1.id_valid    = id_valid;
  assign if_p1.rs1_is_zero = rs1_is_zero;
  assign if_p1.ex_is_load  = ex_is_load;
  assign if_p1.ex_rd       = ex_rd;
  assign if_p1.mem_stall   = mem_stall;
  assign if_p3.id_instr    = id_instr;
  assign if_p3.id_valid    = id_valid;
  assign if_p3.rs1_is_zero = rs1_is_zero;
  assign if_p3.ex_is_load  = ex_is_load;
  assign if_p3.ex_rd       = ex_rd;
  assign if_p3.mem_stall   = mem_stall;

  fetch_flow_ctrl u_p1 (
    .clk (clk),
    .rst (rst),
    .ffc (if_p1)
  );

  fetch_flow_ctrl #(.BRANCH_PENALTY(3)) u_p3 (
    .clk (clk),
    .rst (rst),
    .ffc (if_p3)
  );

  logic [9:0] obs1;
  logic [9:0] obs3;
  assign obs1 = {if_p1.instruction_fetch_en, if_p1.branch_taken, if_p1.if_id_flush,
                 if_p1.id_ex_bubble, if_p1.branch_offset_imm};
  assign obs3 = {if_p3.instruction_fetch_en, if_p3.branch_taken, if_p3.if_id_flush,
                 if_p3.id_ex_bubble, if_p3.branch_offset_imm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int unsigned v);
    return ((v > 65535) ? 16'hFFFF : v[15:0]) & EN_MASK;
  endfunction

  // Drive a new input vector mid-cycle, then let combinational outputs settle.
  task automatic apply(input logic [15:0] ins, input logic vld, input logic z,
                       input logic ld, input logic [2:0] rd, input logic ms_i);
    @(posedge clk);
    #2;
    id_instr    = ins;
    id_valid    = vld;
    rs1_is_zero = z;
    ex_is_load  = ld;
    ex_rd       = rd;
    mem_stall   = ms_i;
    #1;
  endtask

  task automatic expect2(input string tag, input logic [9:0] e1, input logic [9:0] e3);
    if (rst) begin
      ms[0] = 0; ms[1] = 0; mb[0] = 0; mb[1] = 0;
    end
    check({tag, " p1 outs"}, 16'(obs1), 16'(e1));
    check({tag, " p3 outs"}, 16'(obs3), 16'(e3));
    check({tag, " p1 stall_count"},  if_p1.stall_count,  cnt_exp(ms[0]));
    check({tag, " p1 branch_count"}, if_p1.branch_count, cnt_exp(mb[0]));
    check({tag, " p3 stall_count"},  if_p3.stall_count,  cnt_exp(ms[1]));
    check({tag, " p3 branch_count"}, if_p3.branch_count, cnt_exp(mb[1]));
    if (!rst) begin
      if (!e1[9]) ms[0]++;
      if (e1[8])  mb[0]++;
      if (!e3[9]) ms[1]++;
      if (e3[8])  mb[1]++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    id_instr = 16'h0; id_valid = 1'b0; rs1_is_zero = 1'b0;
    ex_is_load = 1'b0; ex_rd = 3'd0; mem_stall = 1'b0;

    @(posedge clk); #3;
    expect2("reset", O0, O0);
    @(posedge clk); #2; rst = 1'b0; #1;
    expect2("rst_release", FE, FE);

    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("idle", FE, FE);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("bz_take", TK3C, TK3C);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("flush_suppress", TK3C, FL);
    apply(BZ_I, 1, 1, 0, 3'd0, 1);   expect2("flush_mstall", O0, FLH);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("flush_last", FE, FL);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("flush_done", FE, FE);
    apply(BNZ_I, 1, 1, 0, 3'd0, 0);  expect2("bnz_not_taken", FE, FE);
    apply(BNZ_I, 1, 0, 0, 3'd0, 0);  expect2("bnz_taken", TK05, TK05);

    // Reset in the middle of the p3 flush sequence.
    @(posedge clk); #2; rst = 1'b1; id_valid = 1'b0; #1;
    expect2("rst_mid_flush", O0, O0);
    @(posedge clk); #2; rst = 1'b0; #1;
    expect2("rst_mid_release", FE, FE);

    apply(LU_I, 1, 0, 1, 3'd3, 0);   expect2("lu_rs2", BUB, BUB);
    apply(LU_I, 1, 0, 1, 3'd3, 0);   expect2("lu_stall_end", FE, FE);
    apply(Z_I, 1, 0, 1, 3'd0, 0);    expect2("lu_rd0", FE, FE);
    apply(RS1_I, 1, 0, 1, 3'd2, 0);  expect2("lu_rs1", BUB, BUB);
    apply(RS1_I, 1, 0, 1, 3'd2, 1);  expect2("stall_mstall", O0, O0);
    apply(RS1_I, 1, 0, 1, 3'd2, 0);  expect2("stall_release", FE, FE);
    apply(RS1_I, 1, 0, 1, 3'd2, 1);  expect2("mstall_over_lu", O0, O0);
    apply(RS1_I, 1, 0, 1, 3'd2, 0);  expect2("lu_after_mstall", BUB, BUB);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("lu_stall2_end", FE, FE);

    apply(BZ_I, 1, 1, 0, 3'd0, 1);   expect2("mstall_over_bt", O0, O0);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("bt_after_mstall", TK3C, TK3C);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bt_pulse_once", FE, FL);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bt_flush3", FE, FL);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bt_run_again", FE, FE);

    apply(BZ_I, 1, 0, 1, 3'd2, 0);   expect2("lu_on_bz_src", BUB, BUB);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("stall_no_branch", FE, FE);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("branch_after_stall", TK3C, TK3C);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bas_flush2", FE, FL);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bas_flush3", FE, FL);
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("bas_run", FE, FE);

`ifdef FETCH_PERF_CNT_EN
    @(posedge clk); #2; rst = 1'b1; #1;
    expect2("perf_reset", O0, O0);
    @(posedge clk); #2; rst = 1'b0; #1;
    expect2("perf_release", FE, FE);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("perf_br1", TK3C, TK3C);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("perf_br2", TK3C, FL);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("perf_br3", TK3C, FL);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("perf_br4", TK3C, TK3C);
    apply(BZ_I, 1, 1, 0, 3'd0, 0);   expect2("perf_br5", TK3C, FL);
    for (int i = 0; i < 7; i++) begin
      apply(16'h0, 0, 0, 0, 3'd0, 1);
      expect2("perf_mstall", O0, FLH);
    end
    apply(16'h0, 0, 0, 0, 3'd0, 0);  expect2("perf_resume", FE, FL);
    check("perf p1 branch_count=5", if_p1.branch_count, 16'd5);
    check("perf p1 stall_count=7",  if_p1.stall_count,  16'd7);

    @(posedge clk); #2; mem_stall = 1'b1;
    repeat (70000) @(posedge clk);
    #3;
    check("perf p1 stall_count saturate", if_p1.stall_count,  16'hFFFF);
    check("perf p1 branch_count hold",    if_p1.branch_count, 16'd5);
    mem_stall = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
